ps2_receiver: RTL

PS2_RECEIVER -- requirements
Module: ps2_receiver

---
 rtl/ps2_receiver.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: synchronizes and filters the PS/2 lines, deframes 11-bit frames
// and assembles E0/F0 prefixed scan codes into a 32-bit key event.
module ps2_receiver #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 13_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [31:0] keyCode,
    output logic        key_valid,
    output logic        frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          fall;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          ext_q, ext_d;
    logic          rel_q, rel_d;
    logic [31:0]   key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          frame_err_q, frame_err_d;

    always_comb begin
        clk_s1_d   = ps2_clk;
        clk_s2_d   = clk_s1_q;
        dat_s1_d   = ps2_data;
        dat_s2_d   = dat_s1_q;
        filt_d     = filt_q;
        filt_cnt_d = '0;
        // Count consecutive samples disagreeing with the filtered level; flip once the run is long enough.
        if (clk_s2_q != filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end
        fall = filt_q & ~filt_d;
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        ext_d       = ext_q;
        rel_d       = rel_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        frame_err_d = 1'b0;

        if (fall || state_q == IDLE) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + TW'(1);
        end

        if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!dat_s2_q) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                START: begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
                DATA: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parity_d = dat_s2_q;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    shift_d = '0;
                    if (dat_s2_q && (^{shift_q, parity_q})) begin
                        if (shift_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            rel_d = 1'b1;
                        end else begin
                            key_code_d  = {8'h00, rel_q ? 8'hF0 : 8'h00,
                                           ext_q ? 8'hE0 : 8'h00, shift_q};
                            key_valid_d = 1'b1;
                            ext_d       = 1'b0;
                            rel_d       = 1'b0;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        ext_d       = 1'b0;
                        rel_d       = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && to_cnt_q >= TW'(TIMEOUT_CYCLES)) begin
            // Stalled frame: drop the partial byte but keep pending prefixes.
            state_d   = IDLE;
            bit_cnt_d = '0;
            shift_d   = '0;
            to_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            filt_q      <= 1'b1;
            filt_cnt_q  <= '0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            to_cnt_q    <= '0;
            ext_q       <= 1'b0;
            rel_q       <= 1'b0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            clk_s1_q    <= clk_s1_d;
            clk_s2_q    <= clk_s2_d;
            dat_s1_q    <= dat_s1_d;
            dat_s2_q    <= dat_s2_d;
            filt_q      <= filt_d;
            filt_cnt_q  <= filt_cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            to_cnt_q    <= to_cnt_d;
            ext_q       <= ext_d;
            rel_q       <= rel_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign keyCode   = key_code_q;
    assign key_valid = key_valid_q;
    assign frame_err = frame_err_q;

endmodule
